// File: rtl/reduce_sub.sv
// reduce_sub: serial popcount subtractor, s = a - popcount(b) mod 2^A_size.
// One bit of b is examined per clock; the accumulator is decremented for
// each set bit. Start/done handshake, fixed latency of B_size cycles.
module reduce_sub #(
  parameter int A_size = 8,
  parameter int B_size = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [A_size-1:0] a,
  input  logic [B_size-1:0] b,
  output logic [A_size-1:0] s,
  output logic              busy,
  output logic              done,
  output logic              borrow
);

  localparam int CW = $clog2(B_size + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [A_size-1:0] r_acc;
  logic [B_size-1:0] r_shreg;
  logic [CW-1:0]     r_cnt;
  logic              r_uf;
  logic [A_size-1:0] r_s;
  logic              r_borrow;
  logic              r_busy;
  logic              r_done;

  logic [A_size-1:0] w_acc_next;
  logic              w_uf_next;
  logic              w_last;

  // Next accumulator/underflow values for the bit currently at shreg[0].
  always_comb begin
    w_acc_next = r_acc;
    w_uf_next  = r_uf;
    if (r_shreg[0]) begin
      w_acc_next = r_acc - {{(A_size-1){1'b0}}, 1'b1};
      w_uf_next  = r_uf | (r_acc == {A_size{1'b0}});
    end else begin
      w_acc_next = r_acc;
      w_uf_next  = r_uf;
    end
    w_last = (r_cnt == CW'(B_size - 1));
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_acc    <= {A_size{1'b0}};
      r_shreg  <= {B_size{1'b0}};
      r_cnt    <= {CW{1'b0}};
      r_uf     <= 1'b0;
      r_s      <= {A_size{1'b0}};
      r_borrow <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_acc   <= a;
            r_shreg <= b;
            r_cnt   <= {CW{1'b0}};
            r_uf    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_acc   <= w_acc_next;
          r_uf    <= w_uf_next;
          r_shreg <= r_shreg >> 1;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            // Final edge: publish the result including this edge's decrement.
            r_s      <= w_acc_next;
            r_borrow <= w_uf_next;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
          end else begin
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign s      = r_s;
  assign borrow = r_borrow;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_reduce_sub.sv
// Self-checking bench for reduce_sub (A_size = B_size = 8).
module tb_reduce_sub;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] s;
  logic       busy;
  logic       done;
  logic       borrow;

  int total = 0;
  int bad   = 0;

  reduce_sub #(.A_size(8), .B_size(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .s(s), .busy(busy), .done(done), .borrow(borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input logic [7:0] ma, input logic [7:0] mb,
                       output logic [7:0] es, output logic eb);
    int pc;
    int diff;
    pc = 0;
    for (int i = 0; i < 8; i++) if (mb[i]) pc++;
    diff = int'(ma) - pc;
    es = 8'((diff + 256) % 256);
    eb = (pc > int'(ma));
  endtask

  // One operation from IDLE; optional disturbance of inputs while running.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tbv,
                        input bit disturb, input string tag);
    int cyc;
    int bcnt;
    logic [7:0] es;
    logic eb;
    model(ta, tbv, es, eb);
    a = ta; b = tbv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; bcnt = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) bcnt++;
      if (disturb) begin
        a = 8'($urandom); b = 8'($urandom); start = (cyc == 3);
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check({tag, "_lat"}, cyc, 32'd8);
    check({tag, "_busycnt"}, bcnt, 32'd8);
    check({tag, "_s"}, s, es);
    check({tag, "_borrow"}, borrow, eb);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    @(posedge clk); #1;
    check({tag, "_done_fall"}, done, 1'b0);
    check({tag, "_s_hold"}, s, es);
  endtask

  initial begin
    int cyc;
    int t1;
    int dcnt;
    logic [7:0] ra;
    logic [7:0] rb;

    rst_n = 1'b0; start = 1'b0; a = 8'd0; b = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s", s, 8'd0);
    check("rst_borrow", borrow, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(8'd10, 8'h0B, 1'b0, "basic");
    run_op(8'd2, 8'hFF, 1'b0, "wrap");
    run_op(8'd0, 8'h01, 1'b0, "wrap0");
    run_op(8'h80, 8'h00, 1'b0, "zero_b");
    run_op(8'd8, 8'hFF, 1'b0, "exact0");

    // Start pulse and input churn mid-run must not disturb the result.
    run_op(8'd20, 8'h0F, 1'b1, "ignore");
    repeat (3) begin
      @(posedge clk); #1;
      check("ignore_no_restart", busy, 1'b0);
    end
    check("ignore_hold", s, 8'd16);

    // Back-to-back with start held high.
    a = 8'd5; b = 8'h03; start = 1'b1;
    @(posedge clk); #1;
    a = 8'd1; b = 8'h06;
    cyc = 0; t1 = 0;
    while (done !== 1'b1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check("b2b1_lat", cyc, 32'd8);
    check("b2b1_s", s, 8'd3);
    check("b2b1_borrow", borrow, 1'b0);
    t1 = cyc;
    @(posedge clk); #1; cyc++;
    start = 1'b0;
    check("b2b_busy_nogap", busy, 1'b1);
    check("b2b_done_fall", done, 1'b0);
    while (done !== 1'b1 && cyc < 60) begin @(posedge clk); #1; cyc++; end
    check("b2b_spacing", cyc - t1, 32'd9);
    check("b2b2_s", s, 8'd255);
    check("b2b2_borrow", borrow, 1'b1);
    @(posedge clk); #1;
    check("b2b_no_third", busy, 1'b0);

    // Reset mid-operation.
    a = 8'd50; b = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_s", s, 8'd0);
    check("mid_rst_borrow", borrow, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    dcnt = 0;
    repeat (6) begin @(posedge clk); #1; if (done === 1'b1) dcnt++; end
    check("mid_rst_nodone", dcnt, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op(8'd200, 8'hA5, 1'b0, "after_rst");

    // Random operations against the reference model.
    for (int i = 0; i < 10; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (i < 3) ra = 8'($urandom_range(0, 7));
      run_op(ra, rb, 1'b0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
